mem_bus_bridge: RTL and testbench
=================================

Name: mem_bus_bridge

Overview:
- Byte-stream-to-memory-bus initiator: decodes host packets from a byte source (UART RX/debug FIFO) into single read/write transactions on the peripheral command bus served by gpio and sibling responders.
- Returns acknowledgements and read data as a byte stream (UART TX).
- Sits between the debug UART and the peripheral address decoder; the decoder generates each responder's mem_cmd_sel from mem_cmd_addr.

Parameters:
- ADDR_W, 16, mem_cmd_addr width; fixed at 16, packet carries 2 address bytes.
- TIMEOUT, 255, max cycles to wait for mem_rsp_ready on a read before abandoning it (1..65535).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_valid  input  1  host byte available
- rx_ready  output  1  bridge accepts rx_data this cycle
- rx_data  input  8  host byte
- tx_valid  output  1  response byte available
- tx_ready  input  1  sink accepts tx_data this cycle
- tx_data  output  8  response byte
- mem_cmd_valid  output  1  one-cycle command strobe
- mem_cmd_wr  output  1  1=write, 0=read
- mem_cmd_addr  output  ADDR_W  byte address
- mem_cmd_wdata  output  32  write data
- mem_rsp_rdata  input  32  read data, valid when mem_rsp_ready=1
- mem_rsp_ready  input  1  read response strobe
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs registered.
- Reset values: state=IDLE; rx_ready=0; tx_valid=0; tx_data=0; mem_cmd_valid=0; mem_cmd_wr=0; mem_cmd_addr=0; mem_cmd_wdata=0; busy=0; byte and timeout counters=0.
- Packet format (host to bridge):
  - Write: 0x57 'W', addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0].
  - Read: 0x52 'R', addr[15:8], addr[7:0].
- Response format (bridge to host):
  - Write: 0x4B 'K'.
  - Read success: 0x44 'D' followed by rdata MSB first (4 bytes).
  - Read timeout: 0x54 'T' only.
- Byte handshake: a byte transfers on a cycle with valid&&ready. rx_ready=1 only in IDLE, ADDR and WDATA.
- tx_valid, once asserted, holds with tx_data stable until tx_ready. The next byte may be presented the cycle after a transfer.
- State machine:
  - IDLE: 'W' goes to ADDR with wr=1. 'R' goes to ADDR with wr=0. Any other byte is consumed and discarded, staying in IDLE with no response.
  - ADDR: two bytes shifted into mem_cmd_addr. Then WDATA if wr, else BUS_RD.
  - WDATA: four bytes shifted into mem_cmd_wdata, then BUS_WR.
  - BUS_WR: mem_cmd_valid=1, mem_cmd_wr=1 for exactly one cycle. The write is complete; no response is expected from the bus. Go to TX_HDR with 'K'.
  - BUS_RD: mem_cmd_valid=1, mem_cmd_wr=0 for exactly one cycle. Go to WAIT_RSP and clear the timeout counter.
  - WAIT_RSP: the counter increments each cycle. On mem_rsp_ready, capture mem_rsp_rdata and go to TX_HDR with 'D'. If the counter reaches TIMEOUT with no ready, go to TX_HDR with 'T'.
  - TX_HDR: present the header byte. After transfer: for 'D' go to TX_DATA, otherwise IDLE.
  - TX_DATA: present captured rdata bytes [31:24], [23:16], [15:8], [7:0] in order, then IDLE.
- Latency: mem_cmd_valid rises on the cycle after the final packet byte transfer. The header tx_valid rises on the cycle after the BUS_WR cycle or the mem_rsp_ready cycle.
- mem_cmd_valid is never high for two consecutive cycles. Responders act on every valid cycle, so duplicate strobes would cause duplicate writes or reads.
- mem_cmd_addr and mem_cmd_wdata stay stable from the strobe until the next packet's bytes begin loading.
- mem_rsp_ready outside WAIT_RSP is ignored, including a late response after a timeout. A ready in the same cycle the counter reaches TIMEOUT counts as success.
- Reset mid-packet or mid-response aborts immediately. Partial bytes are lost and any pending tx byte is dropped.

Test Plan:
- Write: rx 57 00 10 00 00 00 A5 -> one cycle with mem_cmd_valid=1, wr=1, addr=0x0010, wdata=0x000000A5, issued the cycle after the last rx byte; tx 4B.
- Read, 1-cycle responder: rx 52 00 18; model returns ready with rdata=0x0000003C one cycle after valid -> exactly one valid with wr=0, addr=0x0018; tx 44 00 00 00 3C.
- Read timeout with TIMEOUT=4: rx 52 01 00, ready never asserted -> tx 54 after the 4th WAIT_RSP cycle. A ready injected 2 cycles later is ignored; busy=0 and the next packet works.
- Back-pressure: tx_ready low 10 cycles during each 'D' response byte -> tx_data stable while held; byte order unchanged; rx_ready=0 throughout.
- Garbage and back-to-back: rx FF 57 00 04 12 34 56 78 52 00 04 -> FF discarded silently. Write strobe, then read strobe with no other mem_cmd_valid cycles; tx 4B, 44 12 34 56 78 (loopback model).
- Async reset: assert reset after 3 bytes of a write packet -> outputs go to reset values immediately with no mem_cmd_valid. After release, a full read packet completes normally.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Host byte-stream to peripheral command-bus initiator: decodes 'W'/'R' packets into single
// bus transactions and returns 'K', 'D'+data or 'T' on the response byte stream.
module mem_bus_bridge #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              mem_cmd_valid,
   output logic              mem_cmd_wr,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [31:0]       mem_cmd_wdata,
   input  logic [31:0]       mem_rsp_rdata,
   input  logic              mem_rsp_ready,
   output logic              busy
);

   localparam logic [7:0] ChW = 8'h57;
   localparam logic [7:0] ChR = 8'h52;
   localparam logic [7:0] ChK = 8'h4B;
   localparam logic [7:0] ChD = 8'h44;
   localparam logic [7:0] ChT = 8'h54;

   typedef enum logic [2:0] {
      StIdle, StAddr, StWdata, StBusWr, StBusRd, StWaitRsp, StTxHdr, StTxData
   } state_e;

   state_e            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [15:0]       tmo_cnt_q, tmo_cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rx_ready_q, rx_ready_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic              busy_q, busy_d;
   logic              rx_fire, tx_fire;

   assign rx_fire = rx_valid && rx_ready_q;
   assign tx_fire = tx_valid_q && tx_ready;

   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      byte_cnt_d = byte_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      rdata_d    = rdata_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;

      unique case (state_q)
         StIdle: begin
            if (rx_fire) begin
               byte_cnt_d = 2'd0;
               if (rx_data == ChW) begin
                  is_wr_d = 1'b1;
                  state_d = StAddr;
               end else if (rx_data == ChR) begin
                  is_wr_d = 1'b0;
                  state_d = StAddr;
               end
            end
         end
         StAddr: begin
            if (rx_fire) begin
               addr_d = {addr_q[ADDR_W-9:0], rx_data};
               if (byte_cnt_q == 2'd1) begin
                  byte_cnt_d = 2'd0;
                  state_d    = is_wr_q ? StWdata : StBusRd;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         StWdata: begin
            if (rx_fire) begin
               wdata_d = {wdata_q[23:0], rx_data};
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_d = 2'd0;
                  state_d    = StBusWr;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         StBusWr: begin
            state_d    = StTxHdr;
            tx_valid_d = 1'b1;
            tx_data_d  = ChK;
         end
         StBusRd: begin
            tmo_cnt_d = 16'd0;
            state_d   = StWaitRsp;
         end
         StWaitRsp: begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            // A response arriving on the expiry cycle still wins.
            if (mem_rsp_ready) begin
               rdata_d    = mem_rsp_rdata;
               state_d    = StTxHdr;
               tx_valid_d = 1'b1;
               tx_data_d  = ChD;
            end else if (tmo_cnt_q + 16'd1 == 16'(TIMEOUT)) begin
               state_d    = StTxHdr;
               tx_valid_d = 1'b1;
               tx_data_d  = ChT;
            end
         end
         StTxHdr: begin
            if (tx_fire) begin
               if (tx_data_q == ChD) begin
                  state_d    = StTxData;
                  byte_cnt_d = 2'd0;
                  tx_data_d  = rdata_q[31:24];
               end else begin
                  state_d    = StIdle;
                  tx_valid_d = 1'b0;
               end
            end
         end
         StTxData: begin
            if (tx_fire) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0:    tx_data_d = rdata_q[23:16];
                  2'd1:    tx_data_d = rdata_q[15:8];
                  2'd2:    tx_data_d = rdata_q[7:0];
                  default: begin
                     state_d    = StIdle;
                     tx_valid_d = 1'b0;
                  end
               endcase
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered outputs are decoded from the next state so they line up with it.
      rx_ready_d  = (state_d == StIdle) || (state_d == StAddr) || (state_d == StWdata);
      cmd_valid_d = (state_d == StBusWr) || (state_d == StBusRd);
      cmd_wr_d    = (state_d == StBusWr);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         is_wr_q     <= 1'b0;
         byte_cnt_q  <= 2'd0;
         tmo_cnt_q   <= 16'd0;
         rdata_q     <= 32'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         rx_ready_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         cmd_valid_q <= 1'b0;
         cmd_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         byte_cnt_q  <= byte_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rdata_q     <= rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rx_ready_q  <= rx_ready_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_wr_q    <= cmd_wr_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_ready      = rx_ready_q;
   assign tx_valid      = tx_valid_q;
   assign tx_data       = tx_data_q;
   assign mem_cmd_valid = cmd_valid_q;
   assign mem_cmd_wr    = cmd_wr_q;
   assign mem_cmd_addr  = addr_q;
   assign mem_cmd_wdata = wdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: expected commands and tx bytes are queued as packets
// are sent and compared as the bridge emits them; a memory model acts as bus responder.
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  rx_data = 8'd0;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        mem_cmd_valid;
   logic        mem_cmd_wr;
   logic [15:0] mem_cmd_addr;
   logic [31:0] mem_cmd_wdata;
   logic [31:0] mem_rsp_rdata = 32'd0;
   logic        mem_rsp_ready = 1'b0;
   logic        busy;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t       exp_cmd[$];
   logic [7:0] exp_tx[$];
   int         n_tests = 0;
   int         n_fail = 0;

   logic [31:0] mem [256];
   logic        rsp_en = 1'b1;
   logic        rsp_pend = 1'b0;
   logic [7:0]  rsp_addr = 8'd0;
   int          inject_req = 0;
   int          inject_ack = 0;
   logic        prev_cmd_valid = 1'b0;
   logic        bp = 1'b0;
   int          hold_cnt = 0;
   logic        held_prev = 1'b0;
   logic [7:0]  prev_tx_data = 8'd0;

   mem_bus_bridge #(
      .ADDR_W  (16),
      .TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_wr    (mem_cmd_wr),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_cmd_wdata (mem_cmd_wdata),
      .mem_rsp_rdata (mem_rsp_rdata),
      .mem_rsp_ready (mem_rsp_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Bus responder / loopback memory, plus the command scoreboard.
   always @(negedge clk) begin
      cmd_t c;
      mem_rsp_ready = 1'b0;
      if (inject_ack != inject_req) begin
         mem_rsp_ready = 1'b1;
         mem_rsp_rdata = 32'hBAD0_BAD0;
         inject_ack    = inject_req;
      end
      if (rsp_pend) begin
         mem_rsp_ready = 1'b1;
         mem_rsp_rdata = mem[rsp_addr];
         rsp_pend      = 1'b0;
      end
      if (mem_cmd_valid) begin
         check("cmd_single_strobe", {31'd0, prev_cmd_valid}, 32'd0);
         if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", exp_cmd.size(), 32'd1);
         end else begin
            c = exp_cmd.pop_front();
            check("cmd_wr", {31'd0, mem_cmd_wr}, {31'd0, c.wr});
            check("cmd_addr", {16'd0, mem_cmd_addr}, {16'd0, c.addr});
            if (c.wr) check("cmd_wdata", mem_cmd_wdata, c.wdata);
         end
         if (mem_cmd_wr) begin
            mem[mem_cmd_addr[7:0]] = mem_cmd_wdata;
         end else if (rsp_en) begin
            rsp_pend = 1'b1;
            rsp_addr = mem_cmd_addr[7:0];
         end
      end
      prev_cmd_valid = mem_cmd_valid;
   end

   // Byte sink with optional back-pressure, plus the tx scoreboard.
   always @(negedge clk) begin
      if (bp && tx_valid) begin
         if (hold_cnt < 10) begin
            tx_ready = 1'b0;
            hold_cnt++;
         end else begin
            tx_ready = 1'b1;
            hold_cnt = 0;
         end
      end else begin
         tx_ready = 1'b1;
      end
      if (held_prev) begin
         check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
         check("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_tx_data});
         check("rx_ready_during_tx", {31'd0, rx_ready}, 32'd0);
      end
      if (tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) check("tx_unexpected", exp_tx.size(), 32'd1);
         else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      held_prev    = tx_valid && !tx_ready;
      prev_tx_data = tx_data;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check("rx_accept_bound", {31'd0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic push_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
      cmd_t c;
      c.wr    = wr;
      c.addr  = addr;
      c.wdata = wdata;
      exp_cmd.push_back(c);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_tx.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         check("idle_bound_txq", exp_tx.size(), 32'd0);
         check("idle_bound_busy", {31'd0, busy}, 32'd0);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      check({tag, "_cmd_valid"}, {31'd0, mem_cmd_valid}, 32'd0);
      check({tag, "_cmd_wr"}, {31'd0, mem_cmd_wr}, 32'd0);
      check({tag, "_addr"}, {16'd0, mem_cmd_addr}, 32'd0);
      check({tag, "_wdata"}, mem_cmd_wdata, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[8'h18] = 32'h0000_003C;
      mem[8'h20] = 32'hA1B2_C3D4;

      #2 reset = 1'b1;
      #1 check_reset_outputs("rst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);

      // Write: strobe one cycle after last byte, 'K' one cycle after that.
      push_cmd(1'b1, 16'h0010, 32'h0000_00A5);
      exp_tx.push_back(8'h4B);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA5);
      @(negedge clk);
      check("wr_strobe_lat", {31'd0, mem_cmd_valid}, 32'd1);
      check("wr_strobe_wr", {31'd0, mem_cmd_wr}, 32'd1);
      check("wr_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("wr_hdr_lat", {31'd0, tx_valid}, 32'd1);
      check("wr_strobe_drop", {31'd0, mem_cmd_valid}, 32'd0);
      wait_idle();

      // Read with a 1-cycle responder.
      push_cmd(1'b0, 16'h0018, 32'd0);
      exp_tx.push_back(8'h44); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h3C);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h18);
      @(negedge clk);
      check("rd_strobe_lat", {31'd0, mem_cmd_valid}, 32'd1);
      check("rd_strobe_wr", {31'd0, mem_cmd_wr}, 32'd0);
      @(negedge clk);
      check("rd_no_hdr_yet", {31'd0, tx_valid}, 32'd0);
      @(negedge clk);
      check("rd_hdr_lat", {31'd0, tx_valid}, 32'd1);
      wait_idle();

      // Read timeout: TIMEOUT=4 wait cycles, then 'T'; a late ready is ignored.
      rsp_en = 1'b0;
      push_cmd(1'b0, 16'h0100, 32'd0);
      exp_tx.push_back(8'h54);
      send_byte(8'h52); send_byte(8'h01); send_byte(8'h00);
      @(negedge clk);
      check("tmo_strobe", {31'd0, mem_cmd_valid}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("tmo_waiting", {31'd0, tx_valid}, 32'd0);
      end
      @(negedge clk);
      check("tmo_hdr_valid", {31'd0, tx_valid}, 32'd1);
      check("tmo_hdr_data", {24'd0, tx_data}, 32'h54);
      repeat (2) @(negedge clk);
      inject_req++;
      repeat (4) @(negedge clk);
      check("tmo_late_busy", {31'd0, busy}, 32'd0);
      check("tmo_late_tx", {31'd0, tx_valid}, 32'd0);
      rsp_en = 1'b1;
      wait_idle();

      // Back-pressure on every response byte.
      bp = 1'b1;
      push_cmd(1'b0, 16'h0020, 32'd0);
      exp_tx.push_back(8'h44); exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
      exp_tx.push_back(8'hC3); exp_tx.push_back(8'hD4);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
      wait_idle();
      bp = 1'b0;

      // Garbage byte, then back-to-back write and read of the same address.
      push_cmd(1'b1, 16'h0004, 32'h1234_5678);
      push_cmd(1'b0, 16'h0004, 32'd0);
      exp_tx.push_back(8'h4B);
      exp_tx.push_back(8'h44); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
      exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
      send_byte(8'hFF);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h04);
      wait_idle();

      // Asynchronous reset part-way through a write packet.
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
      @(negedge clk);
      reset = 1'b1;
      #1 check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push_cmd(1'b0, 16'h0018, 32'd0);
      exp_tx.push_back(8'h44); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h3C);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h18);
      wait_idle();

      check("cmd_queue_drained", exp_cmd.size(), 32'd0);
      check("tx_queue_drained", exp_tx.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
